// File: rtl/alu_shr_sub.sv
// Multi-cycle subtract / shift-right unit with Start/Busy/Done handshake.
// Define SHR_ARITH_EN for an arithmetic (sign-filling) shift; the default is a logical shift.
module alu_shr_sub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Control,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Zero,
  output logic       Carry
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] sr, sr_nx, res_nx;
  logic [3:0] cnt, cnt_nx, cnt_ld;
  logic       fill, fill_nx, zero_nx, carry_nx;
  logic [8:0] diff;
  logic [7:0] sr_sh;

  // bit 8 of the widened difference is the unsigned borrow
  assign diff   = {1'b0, A} - {1'b0, B};
  assign cnt_ld = (B >= 8'd8) ? 4'd8 : B[3:0];
  assign sr_sh  = {fill, sr[7:1]};

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    fill_nx  = fill;
    res_nx   = Result;
    zero_nx  = Zero;
    carry_nx = Carry;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (Start) begin
          if (!Control) begin
            res_nx   = diff[7:0];
            carry_nx = diff[8];
            zero_nx  = (diff[7:0] == 8'd0);
            state_nx = DONE;
          end else begin
            sr_nx  = A;
            cnt_nx = cnt_ld;
`ifdef SHR_ARITH_EN
            fill_nx = A[7];
`else
            fill_nx = 1'b0;
`endif
            if (cnt_ld == 4'd0) begin
              res_nx   = A;
              carry_nx = 1'b0;
              zero_nx  = (A == 8'd0);
              state_nx = DONE;
            end else begin
              state_nx = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        sr_nx  = sr_sh;
        cnt_nx = cnt - 4'd1;
        // outputs only see the final shifted value, never intermediates
        if (cnt == 4'd1) begin
          res_nx   = sr_sh;
          carry_nx = sr[0];
          zero_nx  = (sr_sh == 8'd0);
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sr     <= 8'd0;
      cnt    <= 4'd0;
      fill   <= 1'b0;
      Result <= 8'd0;
      Zero   <= 1'b1;
      Carry  <= 1'b0;
    end else begin
      state  <= state_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      fill   <= fill_nx;
      Result <= res_nx;
      Zero   <= zero_nx;
      Carry  <= carry_nx;
    end
  end

endmodule
